bus_controller_dbus_arbiter: RTL and testbench
==============================================

BUS_CONTROLLER_DBUS_ARBITER -- requirements
Module: bus_controller_dbus_arbiter

Interface
REQ-001 Parameter: NUM_CORES, 2, number of dcache requesters.
REQ-002 Parameter: Q_DEPTH, BUS_CONTROLLER_DBUS_REQ_Q_DEPTH (8), request FIFO entries.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 dbus_req_valid  in  NUM_CORES  per-core block read request.
REQ-006 dbus_req_block_addr  in  NUM_CORES x BLOCK_ADDR_SPACE_WIDTH  requested block.
REQ-007 dbus_req_exclusive  in  NUM_CORES  1=read-for-ownership, 0=shared read.
REQ-008 dbus_req_ready  out  NUM_CORES  grant; a request transfers when valid&ready.
REQ-009 snoop_valid  out  NUM_CORES  one-cycle snoop pulse to every non-requesting core.
REQ-010 snoop_block_addr, snoop_exclusive  out  BLOCK_ADDR_SPACE_WIDTH, 1  snooped block and type.
REQ-011 mem_ren  out  1  memory read enable.
REQ-012 mem_addr  out  WORD_ADDR_SPACE_WIDTH  word address: {block_addr, word offset}.
REQ-013 mem_state  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-014 mem_rdata  in  32  read word, valid when mem_state==ACCESS.
REQ-015 dbus_resp_valid  out  1  one-cycle response pulse.
REQ-016 dbus_resp_core, dbus_resp_block_addr, dbus_resp_exclusive, dbus_resp_data  out  $clog2(NUM_CORES), BLOCK_ADDR_SPACE_WIDTH, 1, 2x32  response fields (data word 0 in [31:0]).

Function
REQ-017 Arbitration SHALL grant at most one core per cycle, round-robin starting at core 0; pointer advances past the granted core after each transfer.
REQ-018 dbus_req_ready SHALL be 0 for all cores when FIFO holds Q_DEPTH entries (full judged on current-cycle occupancy; a same-cycle dequeue does not enable enqueue).
REQ-019 On each transfer the block SHALL enqueue {core, addr, exclusive} and assert snoop_valid to all other cores in the following cycle with that addr/exclusive.
REQ-020 FSM states: IDLE, READ0, READ1, RESP; reset state IDLE.
REQ-021 IDLE -> READ0 when FIFO non-empty; head dequeued into an entry register on this transition.
REQ-022 READ0/READ1 SHALL hold mem_ren=1 with word offset 0/1; FREE or BUSY holds state; ERROR re-issues the same word (stays); ACCESS captures mem_rdata and advances (READ0->READ1->RESP).
REQ-023 RESP SHALL assert dbus_resp_valid for exactly one cycle with the captured entry and both words, then -> IDLE; minimum request-to-response latency 4 cycles with single-cycle ACCESS.
REQ-024 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; FIFO pointers wrap modulo Q_DEPTH.

Reset
REQ-025 While RST=1: FSM IDLE, FIFO empty, RR pointer 0, all outputs 0; an in-flight memory read is abandoned, no response issued.

Configuration
REQ-026 With DBUS_ARBITER_FIXED_PRIORITY_EN defined, grant SHALL be fixed priority (lowest core index wins) and the RR pointer is removed; undefined: round-robin per REQ-017.

Structure
REQ-027 ramstate_t, BUS_CONTROLLER_DBUS_REQ_Q_DEPTH, and a dbus_req_entry_t struct {core, block_addr, exclusive} SHALL reside in mem_types_pkg.
REQ-028 The FIFO SHALL be a sub-module bus_controller_dbus_req_q (enq/deq/full/empty).

Verification
REQ-029 Both cores request addr 0x10 and 0x20 continuously -> grants alternate core0, core1, core0; snoop_valid=2'b10 then 2'b01.
REQ-030 Single request core0 addr 0x5, mem ACCESS immediately, rdata 0xA then 0xB -> dbus_resp_valid 4 cycles later, core 0, data {0xB,0xA}.
REQ-031 mem_state ERROR once during READ1 -> mem_addr word offset 1 re-issued, response data still correct.
REQ-032 Fill 8 entries with memory BUSY -> dbus_req_ready=0 both cores; one dequeue -> ready returns next cycle.
REQ-033 Assert RST during READ1 -> mem_ren, dbus_resp_valid drop immediately; no response after release; FIFO empty.
REQ-034 Macro defined, both cores requesting -> core0 granted every cycle until its valid drops.

Source files
------------

// File: rtl/mem_types_pkg.sv
// Shared memory-side types for the bus controller: RAM handshake states, address widths
// and the dbus request entry queued by the arbiter.
package mem_types_pkg;

    localparam int unsigned WORD_ADDR_SPACE_WIDTH           = 32;
    localparam int unsigned WORD_OFFSET_WIDTH               = 1;
    localparam int unsigned BLOCK_ADDR_SPACE_WIDTH          = WORD_ADDR_SPACE_WIDTH - WORD_OFFSET_WIDTH;
    localparam int unsigned BUS_CONTROLLER_DBUS_REQ_Q_DEPTH = 8;
    localparam int unsigned DBUS_MAX_CORES                  = 2;
    localparam int unsigned DBUS_CORE_ID_WIDTH              = $clog2(DBUS_MAX_CORES);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef struct packed {
        logic [DBUS_CORE_ID_WIDTH-1:0]     core;
        logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr;
        logic                              exclusive;
    } dbus_req_entry_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead0 = 2'd1,
        StRead1 = 2'd2,
        StResp  = 2'd3
    } dbus_arb_state_e;

    function automatic logic [WORD_ADDR_SPACE_WIDTH-1:0] dbus_word_addr(
        input logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr,
        input logic [WORD_OFFSET_WIDTH-1:0]      offset
    );
        return {block_addr, offset};
    endfunction

endpackage

// File: rtl/bus_controller_dbus_req_q.sv
// Circular request FIFO between the dbus arbiter and the memory read engine.
// Pushes are dropped when full and pops are ignored when empty.
module bus_controller_dbus_req_q
    import mem_types_pkg::*;
#(
    parameter int unsigned Depth = BUS_CONTROLLER_DBUS_REQ_Q_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enq_i,
    input  dbus_req_entry_t enq_data_i,
    input  logic            deq_i,
    output dbus_req_entry_t deq_data_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    dbus_req_entry_t mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty;
    logic            do_enq, do_deq;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full       = (count_q == CntW'(Depth));
    assign empty      = (count_q == '0);
    assign full_o     = full;
    assign empty_o    = empty;
    assign deq_data_o = mem_q[rd_ptr_q];
    assign do_enq     = enq_i & ~full;
    assign do_deq     = deq_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/bus_controller_dbus_arbiter.sv
// Dcache bus arbiter: grants one core per cycle into a request FIFO, snoops the other cores,
// then reads each queued block as two words. DBUS_ARBITER_FIXED_PRIORITY_EN selects fixed priority.
module bus_controller_dbus_arbiter
    import mem_types_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned Q_DEPTH   = BUS_CONTROLLER_DBUS_REQ_Q_DEPTH,
    localparam int unsigned CoreIdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                                        CLK,
    input  logic                                        RST,
    input  logic [NUM_CORES-1:0]                        dbus_req_valid,
    input  logic [NUM_CORES*BLOCK_ADDR_SPACE_WIDTH-1:0] dbus_req_block_addr,
    input  logic [NUM_CORES-1:0]                        dbus_req_exclusive,
    output logic [NUM_CORES-1:0]                        dbus_req_ready,
    output logic [NUM_CORES-1:0]                        snoop_valid,
    output logic [BLOCK_ADDR_SPACE_WIDTH-1:0]           snoop_block_addr,
    output logic                                        snoop_exclusive,
    output logic                                        mem_ren,
    output logic [WORD_ADDR_SPACE_WIDTH-1:0]            mem_addr,
    input  ramstate_t                                   mem_state,
    input  logic [31:0]                                 mem_rdata,
    output logic                                        dbus_resp_valid,
    output logic [CoreIdxW-1:0]                         dbus_resp_core,
    output logic [BLOCK_ADDR_SPACE_WIDTH-1:0]           dbus_resp_block_addr,
    output logic                                        dbus_resp_exclusive,
    output logic [63:0]                                 dbus_resp_data
);

    logic [CoreIdxW-1:0]               grant_idx;
    logic [CoreIdxW-1:0]               cand;
    logic                              grant_any;
    logic [NUM_CORES-1:0]              grant_oh;
    logic                              xfer;
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] grant_addr;
    dbus_req_entry_t                   enq_entry;
    dbus_req_entry_t                   q_head;
    logic                              q_full, q_empty, deq;

    logic [NUM_CORES-1:0]              snoop_valid_q;
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] snoop_addr_q;
    logic                              snoop_excl_q;

    dbus_arb_state_e                   state_q, state_d;
    dbus_req_entry_t                   entry_q, entry_d;
    logic [31:0]                       word0_q, word0_d;
    logic [31:0]                       word1_q, word1_d;

    // ---------------------------------------------------------------- arbitration
`ifdef DBUS_ARBITER_FIXED_PRIORITY_EN
`else
    logic [CoreIdxW-1:0] rr_ptr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_q <= '0;
        end else if (xfer) begin
            rr_ptr_q <= (grant_idx == CoreIdxW'(NUM_CORES - 1)) ? '0 : grant_idx + CoreIdxW'(1);
        end
    end
`endif

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
`ifdef DBUS_ARBITER_FIXED_PRIORITY_EN
            cand = CoreIdxW'(k);
`else
            cand = CoreIdxW'((int'(rr_ptr_q) + k) % int'(NUM_CORES));
`endif
            if (dbus_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign xfer       = grant_any & ~q_full & ~RST;
    assign grant_oh   = NUM_CORES'(1) << grant_idx;
    assign grant_addr = dbus_req_block_addr[int'(grant_idx)*BLOCK_ADDR_SPACE_WIDTH +:
                                            BLOCK_ADDR_SPACE_WIDTH];

    always_comb begin
        dbus_req_ready = '0;
        if (xfer) begin
            dbus_req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        enq_entry            = '0;
        enq_entry.core       = DBUS_CORE_ID_WIDTH'(grant_idx);
        enq_entry.block_addr = grant_addr;
        enq_entry.exclusive  = dbus_req_exclusive[grant_idx];
    end

    bus_controller_dbus_req_q #(
        .Depth (Q_DEPTH)
    ) u_req_q (
        .clk_i      (CLK),
        .rst_i      (RST),
        .enq_i      (xfer),
        .enq_data_i (enq_entry),
        .deq_i      (deq),
        .deq_data_o (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    // ---------------------------------------------------------------- snoop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snoop_valid_q <= '0;
            snoop_addr_q  <= '0;
            snoop_excl_q  <= 1'b0;
        end else begin
            snoop_valid_q <= xfer ? ~grant_oh : '0;
            if (xfer) begin
                snoop_addr_q <= grant_addr;
                snoop_excl_q <= dbus_req_exclusive[grant_idx];
            end
        end
    end

    assign snoop_valid      = snoop_valid_q;
    assign snoop_block_addr = snoop_addr_q;
    assign snoop_exclusive  = snoop_excl_q;

    // ---------------------------------------------------------------- memory read engine
    always_comb begin
        state_d              = state_q;
        entry_d              = entry_q;
        word0_d              = word0_q;
        word1_d              = word1_q;
        deq                  = 1'b0;
        mem_ren              = 1'b0;
        mem_addr             = '0;
        dbus_resp_valid      = 1'b0;
        dbus_resp_core       = '0;
        dbus_resp_block_addr = '0;
        dbus_resp_exclusive  = 1'b0;
        dbus_resp_data       = '0;
        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    deq     = 1'b1;
                    entry_d = q_head;
                    state_d = StRead0;
                end
            end
            StRead0: begin
                mem_ren  = 1'b1;
                mem_addr = dbus_word_addr(entry_q.block_addr, 1'b0);
                // FREE/BUSY wait, ERROR simply keeps the same word on the bus.
                if (mem_state == ACCESS) begin
                    word0_d = mem_rdata;
                    state_d = StRead1;
                end
            end
            StRead1: begin
                mem_ren  = 1'b1;
                mem_addr = dbus_word_addr(entry_q.block_addr, 1'b1);
                if (mem_state == ACCESS) begin
                    word1_d = mem_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                dbus_resp_valid      = 1'b1;
                dbus_resp_core       = CoreIdxW'(entry_q.core);
                dbus_resp_block_addr = entry_q.block_addr;
                dbus_resp_exclusive  = entry_q.exclusive;
                dbus_resp_data       = {word1_q, word0_q};
                state_d              = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            entry_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
        end
    end

endmodule

// File: tb/tb_bus_controller_dbus_arbiter.sv
// Self-checking bench for bus_controller_dbus_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level model (queue of requests plus one active job).
module tb_bus_controller_dbus_arbiter;
    import mem_types_pkg::*;

    localparam int QD = 8;

    logic        CLK;
    logic        RST;
    logic [1:0]  dbus_req_valid;
    logic [61:0] dbus_req_block_addr;
    logic [1:0]  dbus_req_exclusive;
    logic [1:0]  dbus_req_ready;
    logic [1:0]  snoop_valid;
    logic [30:0] snoop_block_addr;
    logic        snoop_exclusive;
    logic        mem_ren;
    logic [31:0] mem_addr;
    ramstate_t   mem_state;
    logic [31:0] mem_rdata;
    logic        dbus_resp_valid;
    logic [0:0]  dbus_resp_core;
    logic [30:0] dbus_resp_block_addr;
    logic        dbus_resp_exclusive;
    logic [63:0] dbus_resp_data;

    bus_controller_dbus_arbiter #(
        .NUM_CORES (2),
        .Q_DEPTH   (QD)
    ) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .dbus_req_valid       (dbus_req_valid),
        .dbus_req_block_addr  (dbus_req_block_addr),
        .dbus_req_exclusive   (dbus_req_exclusive),
        .dbus_req_ready       (dbus_req_ready),
        .snoop_valid          (snoop_valid),
        .snoop_block_addr     (snoop_block_addr),
        .snoop_exclusive      (snoop_exclusive),
        .mem_ren              (mem_ren),
        .mem_addr             (mem_addr),
        .mem_state            (mem_state),
        .mem_rdata            (mem_rdata),
        .dbus_resp_valid      (dbus_resp_valid),
        .dbus_resp_core       (dbus_resp_core),
        .dbus_resp_block_addr (dbus_resp_block_addr),
        .dbus_resp_exclusive  (dbus_resp_exclusive),
        .dbus_resp_data       (dbus_resp_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] wa);
        if (wa == {31'h5, 1'b0}) return 32'h0000_000A;
        if (wa == {31'h5, 1'b1}) return 32'h0000_000B;
        return (wa * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always_comb mem_rdata = (mem_state == ACCESS) ? memf(mem_addr) : 32'hBAD0_BAD0;

    typedef struct {
        int          core;
        logic [30:0] addr;
        logic        excl;
    } req_t;

    int          errors, checks, cyc;
    int          xfer_cyc, last_resp_cyc;
    logic [63:0] last_resp_data;

    req_t        q[$];
    req_t        job;
    int          rr;
    bit          job_act, resp_now;
    logic        widx;
    logic [31:0] w0, w1;
    logic [1:0]  snp_v;
    logic [30:0] snp_a;
    logic        snp_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        rr       = 0;
        job_act  = 0;
        resp_now = 0;
        widx     = 1'b0;
        snp_v    = 2'b00;
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [30:0] a0,
                        input logic [30:0] a1, input logic [1:0] ex, input ramstate_t ms);
        int          g;
        logic [1:0]  exp_rdy;
        logic [30:0] ga;
        req_t        nr;
        RST                 = r;
        dbus_req_valid      = v;
        dbus_req_block_addr = {a1, a0};
        dbus_req_exclusive  = ex;
        mem_state           = ms;
        if (r) model_clear();
        #3;
        g = -1;
        if (!r && q.size() < QD) begin
`ifdef DBUS_ARBITER_FIXED_PRIORITY_EN
            for (int k = 0; k < 2; k++) if (g < 0 && v[k]) g = k;
`else
            for (int k = 0; k < 2; k++) if (g < 0 && v[(rr + k) % 2]) g = (rr + k) % 2;
`endif
        end
        exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
        ga      = (g == 1) ? a1 : a0;

        chk("ready", 64'(dbus_req_ready), 64'(exp_rdy));
        chk("snoop_valid", 64'(snoop_valid), 64'(snp_v));
        if (snp_v != 2'b00) begin
            chk("snoop_addr", 64'(snoop_block_addr), 64'(snp_a));
            chk("snoop_excl", 64'(snoop_exclusive), 64'(snp_e));
        end
        chk("mem_ren", 64'(mem_ren), 64'(job_act && !resp_now));
        if (job_act && !resp_now) chk("mem_addr", 64'(mem_addr), 64'({job.addr, widx}));
        chk("resp_valid", 64'(dbus_resp_valid), 64'(resp_now));
        if (resp_now) begin
            chk("resp_core", 64'(dbus_resp_core), 64'(job.core));
            chk("resp_addr", 64'(dbus_resp_block_addr), 64'(job.addr));
            chk("resp_excl", 64'(dbus_resp_exclusive), 64'(job.excl));
            chk("resp_data", dbus_resp_data, {w1, w0});
        end
        if (r) begin
            chk("rst_ctrl", 64'({dbus_req_ready, snoop_valid, snoop_exclusive, mem_ren,
                                 dbus_resp_valid, dbus_resp_core, dbus_resp_exclusive}), 64'd0);
            chk("rst_addr", 64'({snoop_block_addr, mem_addr}), 64'd0);
            chk("rst_resp", 64'(dbus_resp_block_addr), 64'd0);
            chk("rst_data", dbus_resp_data, 64'd0);
        end
        if (dbus_resp_valid) begin
            last_resp_cyc  = cyc;
            last_resp_data = dbus_resp_data;
        end

        @(posedge CLK);
        cyc++;
        if (!r) begin
            if (job_act && resp_now) begin
                job_act  = 0;
                resp_now = 0;
            end else if (job_act) begin
                if (ms == ACCESS) begin
                    if (!widx) begin
                        w0   = memf({job.addr, 1'b0});
                        widx = 1'b1;
                    end else begin
                        w1       = memf({job.addr, 1'b1});
                        resp_now = 1;
                    end
                end
            end else if (q.size() != 0) begin
                job     = q.pop_front();
                job_act = 1;
                widx    = 1'b0;
            end
            snp_v = 2'b00;
            if (g >= 0) begin
                nr.core = g;
                nr.addr = ga;
                nr.excl = ex[g];
                q.push_back(nr);
                rr    = (g + 1) % 2;
                snp_v = 2'b11 ^ (2'b01 << g);
                snp_a = ga;
                snp_e = ex[g];
            end
        end
        #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        last_resp_cyc = -1;
        w0            = '0;
        w1            = '0;
        snp_a         = '0;
        snp_e         = 1'b0;
        model_clear();

        // Reset state.
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, FREE);
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, FREE);

        // Both cores requesting continuously with memory stalled.
        repeat (4) step(1'b0, 2'b11, 31'h10, 31'h20, 2'b01, BUSY);
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, FREE);

        // Single request with immediate ACCESS: minimum latency and word order.
        xfer_cyc = cyc;
        step(1'b0, 2'b01, 31'h5, 31'h0, 2'b00, ACCESS);
        repeat (6) step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);
        chk("latency", 64'(last_resp_cyc - xfer_cyc), 64'd4);
        chk("resp_data_ab", last_resp_data, 64'h0000_000B_0000_000A);

        // ERROR once while reading word 1.
        step(1'b0, 2'b10, 31'h0, 31'h33, 2'b10, FREE);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, FREE);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ERROR);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);
        repeat (2) step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, FREE);

        // Fill the queue behind a stalled read, then drain.
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, FREE);
        repeat (12) step(1'b0, 2'b11, 31'h40, 31'h41, 2'b00, BUSY);
        repeat (8) step(1'b0, 2'b11, 31'h42, 31'h43, 2'b11, ACCESS);

        // Reset while reading word 1.
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, FREE);
        step(1'b0, 2'b01, 31'h7, 31'h0, 2'b01, FREE);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, FREE);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);
        step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, BUSY);
        step(1'b1, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);
        repeat (6) step(1'b0, 2'b00, 31'h0, 31'h0, 2'b00, ACCESS);

        // Random traffic.
        repeat (400) begin
            step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 31'($urandom_range(0, 255)),
                 31'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)),
                 ramstate_t'(2'($urandom_range(0, 3))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
